// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with hold-until-ack memory request and a small PC/instruction buffer
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall_i                        decode not accepting this cycle
//   branch_flag_i, branch_target_i redirect request and target (low two bits ignored)
//   mem_req_o, mem_addr_o          registered fetch request and word address
//   mem_ack_i, mem_rdata_i         memory accept and same-cycle instruction word
//   valid_o, pc_o, inst_o          buffer head presented to decode (zeroed when empty)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_hs;
  logic          w_valid;
  logic          w_enq;
  logic          w_pop;
  logic          w_issue;
  logic [CW-1:0] w_cnt_next;
  logic [31:0]   w_target;
  logic [31:0]   w_next_addr;
  logic [AW-1:0] w_rd_inc;
  logic [AW-1:0] w_wr_inc;
  always_comb begin
    w_hs        = r_req & mem_ack_i;
    w_valid     = r_cnt != '0;
    // only a handshake in REQ carries live data; DRAIN returns the stale word
    w_enq       = w_hs & (r_state == REQ) & ~branch_flag_i;
    w_pop       = w_valid & ~stall_i & ~branch_flag_i;
    w_cnt_next  = r_cnt + CW'(w_enq) - CW'(w_pop);
    w_issue     = w_cnt_next < CW'(DEPTH);
    w_target    = branch_target_i & ~32'h3;
    w_next_addr = r_addr + 32'd4;
    w_rd_inc    = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
    w_wr_inc    = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
    end else if (branch_flag_i) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
      r_fetch_pc <= w_target;
      // an unacked request must complete at its old address before the target is fetched
      if (r_state == IDLE || w_hs) begin
        r_state <= REQ;
        r_req   <= 1'b1;
        r_addr  <= w_target;
      end else begin
        r_state <= DRAIN;
      end
    end else begin
      r_cnt <= w_cnt_next;
      if (w_enq) begin
        r_wr       <= w_wr_inc;
        r_fetch_pc <= w_next_addr;
      end
      if (w_pop) r_rd <= w_rd_inc;
      if (r_state == IDLE && w_issue) begin
        r_state <= REQ;
        r_req   <= 1'b1;
        r_addr  <= r_fetch_pc;
      end else if (r_state == REQ && w_hs) begin
        if (w_issue) r_addr <= w_next_addr;
        else begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      end else if (r_state == DRAIN && w_hs) begin
        r_state <= REQ;
        r_addr  <= r_fetch_pc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_pc[r_wr]   <= r_addr;
      r_inst[r_wr] <= mem_rdata_i;
    end
  end
  assign mem_req_o  = r_req;
  assign mem_addr_o = r_addr;
  assign valid_o    = w_valid;
  assign pc_o       = w_valid ? r_pc[r_rd] : 32'h0;
  assign inst_o     = w_valid ? r_inst[r_rd] : 32'h0;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst, stall, br;
  logic [31:0] tgt;
  logic        auto_ack, man_ack, ack;
  logic        req, req_w, valid, valid_w;
  logic [31:0] addr, addr_w, rdata, rdata_w, pc, pc_w, inst, inst_w;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  always_comb begin
    ack     = auto_ack ? req : man_ack;
    rdata   = addr ^ 32'hA5A5_0000;
    rdata_w = addr_w ^ 32'hA5A5_0000;
  end
  if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .mem_req_o(req), .mem_addr_o(addr), .mem_ack_i(ack), .mem_rdata_i(rdata),
    .valid_o(valid), .pc_o(pc), .inst_o(inst));
  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .mem_req_o(req_w), .mem_addr_o(addr_w), .mem_ack_i(ack), .mem_rdata_i(rdata_w),
    .valid_o(valid_w), .pc_o(pc_w), .inst_o(inst_w));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic a);
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; auto_ack = a; man_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; auto_ack = 1'b1; man_ack = 1'b0;
    tick(); tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", req); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", addr); end
    checks++; if ({valid, pc, inst} !== 65'h0) begin errors++; $display("FAIL reset_out: got %b %h %h exp 0", valid, pc, inst); end
    checks++; if (addr_w !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr_w: got %h exp fffffff8", addr_w); end
  endtask
  task automatic test_stream();
    do_reset(1'b1);
    tick();
    checks++; if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL stream_first_req: got %b %h %b exp 1 0 0", req, addr, valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (valid !== 1'b1 || pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d: got %b %h exp 1 %h", k, valid, pc, 4 * k); end
      checks++; if (inst !== (32'(4 * k) ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_inst%0d: got %h exp %h", k, inst, 32'(4 * k) ^ 32'hA5A5_0000); end
    end
  endtask
  task automatic test_stall();
    do_reset(1'b1);
    stall = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (req !== 1'b0 || valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL stall_hold%0d: got %b %b %h exp 0 1 0", k, req, valid, pc); end
      if (k < 2) tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h4 || req !== 1'b1 || addr !== 32'h8) begin errors++; $display("FAIL stall_release: got %h %b %h exp 4 1 8", pc, req, addr); end
    tick();
    checks++; if (pc !== 32'h8 || valid !== 1'b1) begin errors++; $display("FAIL stall_pc8: got %b %h exp 1 8", valid, pc); end
    tick();
    checks++; if (pc !== 32'hC || valid !== 1'b1) begin errors++; $display("FAIL stall_pcC: got %b %h exp 1 c", valid, pc); end
  endtask
  task automatic test_wait();
    do_reset(1'b0);
    tick();
    for (int w = 0; w < 2; w++) begin
      man_ack = 1'b0;
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++; if (req !== 1'b1 || addr !== 32'(4 * w) || valid !== 1'b0) begin errors++; $display("FAIL wait_hold%0d_%0d: got %b %h %b exp 1 %h 0", w, c, req, addr, valid, 4 * w); end
      end
      man_ack = 1'b1;
      tick();
      checks++; if (valid !== 1'b1 || pc !== 32'(4 * w)) begin errors++; $display("FAIL wait_word%0d: got %b %h exp 1 %h", w, valid, pc, 4 * w); end
    end
    man_ack = 1'b0;
  endtask
  task automatic test_redirect_idle();
    do_reset(1'b1);
    tick(); tick(); tick();
    checks++; if (addr !== 32'h8 || pc !== 32'h4) begin errors++; $display("FAIL rdi_pre: got %h %h exp 8 4", addr, pc); end
    br = 1'b1; tgt = 32'h0000_0103;
    tick();
    br = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin errors++; $display("FAIL rdi_flush: got %b %b %h exp 0 1 100", valid, req, addr); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h100 || inst !== 32'hA5A5_0100) begin errors++; $display("FAIL rdi_target: got %b %h %h exp 1 100 a5a50100", valid, pc, inst); end
    tick();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL rdi_next: got %h exp 104", pc); end
  endtask
  task automatic test_redirect_drain();
    do_reset(1'b0);
    tick();
    man_ack = 1'b1;
    tick(); tick(); tick();
    checks++; if (pc !== 32'h8 || addr !== 32'hC) begin errors++; $display("FAIL rdd_pre: got %h %h exp 8 c", pc, addr); end
    man_ack = 1'b0; br = 1'b1; tgt = 32'h200;
    tick();
    br = 1'b0;
    checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'hC) begin errors++; $display("FAIL rdd_drain: got %b %b %h exp 0 1 c", valid, req, addr); end
    tick();
    checks++; if (valid !== 1'b0 || addr !== 32'hC) begin errors++; $display("FAIL rdd_hold: got %b %h exp 0 c", valid, addr); end
    man_ack = 1'b1;
    tick();
    checks++; if (valid !== 1'b0 || addr !== 32'h200) begin errors++; $display("FAIL rdd_stale_drop: got %b %h %h exp 0 200", valid, pc, addr); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h200 || addr !== 32'h204) begin errors++; $display("FAIL rdd_target: got %b %h %h exp 1 200 204", valid, pc, addr); end
    man_ack = 1'b0; br = 1'b1; tgt = 32'h250;
    tick();
    tgt = 32'h300;
    checks++; if (valid !== 1'b0 || addr !== 32'h204) begin errors++; $display("FAIL rdd_second_drain: got %b %h exp 0 204", valid, addr); end
    tick();
    br = 1'b0; man_ack = 1'b1;
    tick();
    checks++; if (valid !== 1'b0 || addr !== 32'h300) begin errors++; $display("FAIL rdd_newest_target: got %b %h exp 0 300", valid, addr); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h300 || inst !== 32'hA5A5_0300) begin errors++; $display("FAIL rdd_300: got %b %h %h exp 1 300 a5a50300", valid, pc, inst); end
    man_ack = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset(1'b0);
    tick();
    man_ack = 1'b1;
    tick(); tick();
    man_ack = 1'b0;
    tick();
    checks++; if (req !== 1'b1 || addr !== 32'h8) begin errors++; $display("FAIL rmid_pending: got %b %h exp 1 8", req, addr); end
    rst = 1'b1; man_ack = 1'b1;
    tick();
    checks++; if (req !== 1'b0 || addr !== 32'h0 || {valid, pc, inst} !== 65'h0) begin errors++; $display("FAIL rmid_reset: got %b %h %b %h %h exp 0 0 0 0 0", req, addr, valid, pc, inst); end
    rst = 1'b0; man_ack = 1'b0; auto_ack = 1'b1;
    tick();
    checks++; if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL rmid_restart: got %b %h %b exp 1 0 0", req, addr, valid); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL rmid_first: got %b %h exp 1 0", valid, pc); end
  endtask
  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    do_reset(1'b1);
    tick();
    checks++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req: got %b %h exp 1 fffffff8", req_w, addr_w); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (valid_w !== 1'b1 || pc_w !== exp_pc[k] || inst_w !== (exp_pc[k] ^ 32'hA5A5_0000)) begin errors++; $display("FAIL wrap_pc%0d: got %b %h %h exp 1 %h %h", k, valid_w, pc_w, inst_w, exp_pc[k], exp_pc[k] ^ 32'hA5A5_0000); end
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_wait();
    test_redirect_idle();
    test_redirect_drain();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
